// File: rtl/tdc_event_builder_pkg.sv
// Shared definitions for the TDC event builder: error codes, FSM encoding,
// and the default widths shared with the TDC core.
package tdc_event_builder_pkg;

  localparam int NBINS_DEF    = 32;
  localparam int FINE_W_DEF   = 5;
  localparam int COARSE_W_DEF = 4;
  localparam int TS_W_DEF     = 16;

  localparam logic [1:0] ERR_OK    = 2'd0;
  localparam logic [1:0] ERR_RANGE = 2'd1;
  localparam logic [1:0] ERR_COVF  = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ARMED   = 2'd1,
    ST_SETTLE  = 2'd2,
    ST_CAPTURE = 2'd3
  } state_t;

endpackage

// File: rtl/tdc_event_builder_fifo.sv
// First-word-fall-through event FIFO; a push while full is ignored unless a
// pop frees the slot in the same cycle.
module tdc_event_builder_fifo #(
  parameter int DEPTH = 4,
  parameter int DW    = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic [DW-1:0] din,
  input  logic          pop,
  output logic [DW-1:0] dout,
  output logic          full,
  output logic          empty
);

  localparam int AW = $clog2(DEPTH);

  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   cnt;
  logic          wr_en, rd_en;

  assign full  = (cnt == (AW+1)'(DEPTH));
  assign empty = (cnt == '0);
  assign rd_en = pop && !empty;
  assign wr_en = push && (!full || rd_en);

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (rd_en) rd_ptr <= rd_ptr + 1'b1;
      case ({wr_en, rd_en})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

  // Head is masked while empty so a drained or reset FIFO presents zeros.
  assign dout = empty ? '0 : mem[rd_ptr];

endmodule

// File: rtl/tdc_event_builder.sv
// Builds pulse-width events from TDC bins once each hit pulse has ended and
// queues them for valid/ready readout.
//   state      | meaning
//   ST_IDLE    | waiting for a synced rising edge of hit
//   ST_ARMED   | pulse high, counting its length in clocks
//   ST_SETTLE  | pulse ended, waiting for TDC outputs to settle
//   ST_CAPTURE | compute width/error and push the event
module tdc_event_builder
  import tdc_event_builder_pkg::*;
#(
  parameter int NBINS    = NBINS_DEF,
  parameter int FINE_W   = FINE_W_DEF,
  parameter int COARSE_W = COARSE_W_DEF,
  parameter int SETTLE   = 2,
  parameter int TS_W     = TS_W_DEF,
  parameter int DEPTH    = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       hit,
  input  logic [FINE_W-1:0]          bin_out_start,
  input  logic [FINE_W-1:0]          bin_out_stop,
  input  logic [COARSE_W-1:0]        out_count,
  input  logic                       clr_stat,
  output logic                       ev_valid,
  input  logic                       ev_ready,
  output logic [COARSE_W+FINE_W-1:0] ev_width,
  output logic [TS_W-1:0]            ev_ts,
  output logic [1:0]                 ev_err,
  output logic [1:0]                 stat,
  output logic [7:0]                 drop_cnt
);

  localparam int W  = COARSE_W + FINE_W;
  localparam int DW = 2 + TS_W + W;
  localparam int SW = $clog2(SETTLE + 1);
  localparam logic [COARSE_W:0] LEN_SAT = {1'b1, {COARSE_W{1'b0}}};
  localparam logic [FINE_W:0]   NBINS_V = (FINE_W+1)'(NBINS);

  logic hit_m, hit_s, hit_d, rise, fall;
  always_ff @(posedge clk) begin
    if (!rst_n) {hit_m, hit_s, hit_d} <= '0;
    else        {hit_m, hit_s, hit_d} <= {hit, hit_m, hit_s};
  end
  assign rise = hit_s && !hit_d;
  assign fall = !hit_s && hit_d;

  logic [TS_W-1:0] ts_cnt;
  always_ff @(posedge clk) begin
    if (!rst_n) ts_cnt <= '0;
    else        ts_cnt <= ts_cnt + 1'b1;
  end

  state_t state, state_nxt;
  logic [SW-1:0]       settle_cnt;
  logic [COARSE_W:0]   len_cnt;
  logic [TS_W-1:0]     ts_cap;
  logic [FINE_W-1:0]   start_q, stop_q;
  logic [COARSE_W-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:    if (rise) state_nxt = ST_ARMED;
      ST_ARMED:   if (fall) state_nxt = ST_SETTLE;
      ST_SETTLE:  if (settle_cnt == SW'(1)) state_nxt = ST_CAPTURE;
      ST_CAPTURE: state_nxt = ST_IDLE;
      default:    state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      settle_cnt <= '0;
      len_cnt    <= '0;
      ts_cap     <= '0;
      start_q    <= '0;
      stop_q     <= '0;
      cnt_q      <= '0;
    end else begin
      case (state)
        ST_IDLE: if (rise) begin
          ts_cap  <= ts_cnt;
          len_cnt <= '0;
        end
        ST_ARMED: begin
          if (len_cnt != LEN_SAT) len_cnt <= len_cnt + 1'b1;
          if (fall) settle_cnt <= SW'(SETTLE);
        end
        ST_SETTLE: begin
          settle_cnt <= settle_cnt - 1'b1;
          if (settle_cnt == SW'(1)) begin
            start_q <= bin_out_start;
            stop_q  <= bin_out_stop;
            cnt_q   <= out_count;
          end
        end
        default: ;
      endcase
    end
  end

  // One extra bit so a stop bin earlier than the start bin shows as negative.
  logic [W:0]   diff;
  logic [W-1:0] width_c;
  logic [1:0]   err_c;
  logic         range_bad;
  assign diff = (W+1)'(cnt_q) * (W+1)'(NBINS) + (W+1)'(stop_q) - (W+1)'(start_q);
  assign range_bad = ({1'b0, start_q} >= NBINS_V) || ({1'b0, stop_q} >= NBINS_V);

  always_comb begin
    width_c = diff[W-1:0];
    err_c   = ERR_OK;
    if (range_bad || diff[W]) begin
      width_c = '0;
      err_c   = ERR_RANGE;
    end else if (len_cnt == LEN_SAT) begin
      width_c = '1;
      err_c   = ERR_COVF;
    end
  end

  logic push, pop, full, empty, drop, pileup;
  assign push   = (state == ST_CAPTURE);
  assign pop    = ev_valid && ev_ready;
  assign drop   = push && full && !pop;
  assign pileup = rise && (state == ST_SETTLE || state == ST_CAPTURE);

  tdc_event_builder_fifo #(.DEPTH(DEPTH), .DW(DW)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .din   ({err_c, ts_cap, width_c}),
    .pop   (pop),
    .dout  ({ev_err, ev_ts, ev_width}),
    .full  (full),
    .empty (empty)
  );
  assign ev_valid = !empty;

  // A set in the same cycle as clr_stat wins over the clear.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stat     <= '0;
      drop_cnt <= '0;
    end else begin
      if (pileup)        stat[1] <= 1'b1;
      else if (clr_stat) stat[1] <= 1'b0;
      if (drop)          stat[0] <= 1'b1;
      else if (clr_stat) stat[0] <= 1'b0;
      if (clr_stat)      drop_cnt <= drop ? 8'd1 : 8'd0;
      else if (drop && drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_tdc_event_builder.sv
// Directed bench for tdc_event_builder: scoreboard of expected events checked
// on every pop, plus latency, status and reset checks.
module tb_tdc_event_builder;

  logic        clk = 1'b0;
  logic        rst_n, hit, hit6, clr_stat, ev_ready, rdy6;
  logic [4:0]  bin_start, bin_stop;
  logic [5:0]  start6, stop6;
  logic [3:0]  out_count;
  logic        ev_valid, v6;
  logic [8:0]  ev_width;
  logic [9:0]  w6;
  logic [15:0] ev_ts, ts6, mts, ts6e;
  logic [1:0]  ev_err, stat, err6, stat6;
  logic [7:0]  drop_cnt, drop6;

  typedef struct {
    logic [8:0]  w;
    logic [15:0] ts;
    logic [1:0]  e;
  } ev_t;
  ev_t exp_q[$];

  int vectors = 0;
  int miscompares = 0;

  tdc_event_builder u_dut (
    .clk(clk), .rst_n(rst_n), .hit(hit), .bin_out_start(bin_start),
    .bin_out_stop(bin_stop), .out_count(out_count), .clr_stat(clr_stat),
    .ev_valid(ev_valid), .ev_ready(ev_ready), .ev_width(ev_width),
    .ev_ts(ev_ts), .ev_err(ev_err), .stat(stat), .drop_cnt(drop_cnt)
  );

  // Wider bin inputs so out-of-range bins can be presented.
  tdc_event_builder #(.FINE_W(6)) u_dut6 (
    .clk(clk), .rst_n(rst_n), .hit(hit6), .bin_out_start(start6),
    .bin_out_stop(stop6), .out_count(out_count), .clr_stat(clr_stat),
    .ev_valid(v6), .ev_ready(rdy6), .ev_width(w6),
    .ev_ts(ts6), .ev_err(err6), .stat(stat6), .drop_cnt(drop6)
  );

  always #5 clk = ~clk;

  always @(posedge clk) mts <= rst_n ? mts + 16'd1 : 16'd0;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic ev_t model(input int s, input int p, input int c,
                                input logic [15:0] ts, input bit sat);
    ev_t e;
    int w;
    w = c * 32 + p - s;
    e.ts = ts;
    if (s >= 32 || p >= 32 || w < 0) begin
      e.w = 9'd0; e.e = 2'd1;
    end else if (sat) begin
      e.w = 9'd511; e.e = 2'd2;
    end else begin
      e.w = 9'(w); e.e = 2'd0;
    end
    return e;
  endfunction

  // Drives one hit pulse of hi clocks; returns right after hit falls.
  task automatic pulse(input int s, input int p, input int c, input int hi,
                       input bit sat, input bit expect_it);
    logic [15:0] ts;
    bin_start = 5'(s);
    bin_stop  = 5'(p);
    out_count = 4'(c);
    hit = 1'b1;
    tick();
    tick();
    ts = mts;
    repeat (hi - 2) tick();
    hit = 1'b0;
    if (expect_it) exp_q.push_back(model(s, p, c, ts, sat));
  endtask

  task automatic wait_pop(input string tag);
    ev_t e;
    int n;
    n = 0;
    while (ev_valid !== 1'b1 && n < 40) begin
      tick();
      n++;
    end
    check({tag, "_valid"}, 32'(ev_valid), 32'd1);
    if (ev_valid === 1'b1 && exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check({tag, "_width"}, 32'(ev_width), 32'(e.w));
      check({tag, "_ts"},    32'(ev_ts),    32'(e.ts));
      check({tag, "_err"},   32'(ev_err),   32'(e.e));
    end
    tick();
  endtask

  initial begin
    ev_t e;
    rst_n = 1'b0; hit = 1'b0; hit6 = 1'b0; clr_stat = 1'b0;
    ev_ready = 1'b1; rdy6 = 1'b0;
    bin_start = '0; bin_stop = '0; start6 = '0; stop6 = '0; out_count = '0;
    repeat (3) tick();
    check("rst_valid", 32'(ev_valid), 32'd0);
    check("rst_width", 32'(ev_width), 32'd0);
    check("rst_ts",    32'(ev_ts),    32'd0);
    check("rst_err",   32'(ev_err),   32'd0);
    check("rst_stat",  32'(stat),     32'd0);
    check("rst_drop",  32'(drop_cnt), 32'd0);
    rst_n = 1'b1;
    repeat (5) tick();

    // Normal pulse with exact output latency.
    pulse(5, 12, 3, 4, 0, 1);
    check("norm_model_width", 32'(exp_q[0].w), 32'd103);
    repeat (5) tick();
    check("lat_early", 32'(ev_valid), 32'd0);
    tick();
    check("lat_valid", 32'(ev_valid), 32'd1);
    wait_pop("normal");
    check("normal_drained", 32'(ev_valid), 32'd0);

    pulse(20, 10, 0, 3, 0, 1);
    wait_pop("negative");
    pulse(3, 30, 2, 3, 0, 1);
    wait_pop("plain");

    pulse(5, 12, 3, 20, 1, 1);
    wait_pop("covf");

    // Backpressure: five pulses into a four-deep FIFO.
    ev_ready = 1'b0;
    pulse(1, 9, 2, 3, 0, 1);   repeat (8) tick();
    pulse(0, 31, 1, 3, 0, 1);  repeat (8) tick();
    pulse(10, 3, 4, 3, 0, 1);  repeat (8) tick();
    pulse(2, 2, 0, 3, 0, 1);   repeat (8) tick();
    pulse(6, 7, 5, 3, 0, 0);   repeat (8) tick();
    check("bp_valid", 32'(ev_valid), 32'd1);
    check("bp_head_width", 32'(ev_width), 32'(exp_q[0].w));
    check("bp_head_ts",    32'(ev_ts),    32'(exp_q[0].ts));
    check("bp_stat",  32'(stat),     32'd1);
    check("bp_drop",  32'(drop_cnt), 32'd1);
    ev_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check($sformatf("drain%0d_valid", i), 32'(ev_valid), 32'd1);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check($sformatf("drain%0d_width", i), 32'(ev_width), 32'(e.w));
        check($sformatf("drain%0d_ts", i),    32'(ev_ts),    32'(e.ts));
        check($sformatf("drain%0d_err", i),   32'(ev_err),   32'(e.e));
      end
      tick();
    end
    check("drain_empty", 32'(ev_valid), 32'd0);
    check("pre_clr_stat", 32'(stat), 32'd1);
    clr_stat = 1'b1;
    tick();
    clr_stat = 1'b0;
    check("clr_stat", 32'(stat),     32'd0);
    check("clr_drop", 32'(drop_cnt), 32'd0);

    // Pile-up: second rise lands while the first event is settling.
    pulse(4, 8, 1, 3, 0, 1);
    tick();
    hit = 1'b1;
    repeat (3) tick();
    hit = 1'b0;
    wait_pop("pileup");
    check("pileup_stat", 32'(stat), 32'd2);
    repeat (12) tick();
    check("pileup_single", 32'(ev_valid), 32'd0);

    // Reset pulse during SETTLE discards the event in flight.
    pulse(4, 9, 1, 3, 0, 0);
    repeat (3) tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    repeat (10) tick();
    check("mrst_valid", 32'(ev_valid), 32'd0);
    check("mrst_width", 32'(ev_width), 32'd0);
    check("mrst_ts",    32'(ev_ts),    32'd0);
    check("mrst_err",   32'(ev_err),   32'd0);
    check("mrst_stat",  32'(stat),     32'd0);
    check("mrst_drop",  32'(drop_cnt), 32'd0);
    pulse(7, 2, 1, 3, 0, 1);
    wait_pop("after_rst");

    // Out-of-range bins on the wide-bin instance.
    start6 = 6'd33; stop6 = 6'd4; out_count = 4'd1;
    hit6 = 1'b1; tick(); tick(); ts6e = mts; tick(); tick(); hit6 = 1'b0;
    repeat (10) tick();
    check("rng_start_valid", 32'(v6),   32'd1);
    check("rng_start_err",   32'(err6), 32'd1);
    check("rng_start_width", 32'(w6),   32'd0);
    check("rng_start_ts",    32'(ts6),  32'(ts6e));
    rdy6 = 1'b1; tick(); rdy6 = 1'b0;
    check("rng_popped", 32'(v6), 32'd0);
    start6 = 6'd2; stop6 = 6'd40; out_count = 4'd0;
    hit6 = 1'b1; repeat (4) tick(); hit6 = 1'b0;
    repeat (10) tick();
    check("rng_stop_valid", 32'(v6),   32'd1);
    check("rng_stop_err",   32'(err6), 32'd1);
    check("rng_stop_width", 32'(w6),   32'd0);
    check("rng_stat6",  32'(stat6), 32'd0);
    check("rng_drop6",  32'(drop6), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
